// File: rtl/router_pkg.sv
// Shared types and constants for the 1x3 router input-side controller.
package router_pkg;

   typedef enum logic [2:0] {
      DECODE_ADDRESS     = 3'd0,
      WAIT_TILL_EMPTY    = 3'd1,
      LOAD_FIRST_DATA    = 3'd2,
      LOAD_DATA          = 3'd3,
      FIFO_FULL_STATE    = 3'd4,
      LOAD_AFTER_FULL    = 3'd5,
      LOAD_PARITY        = 3'd6,
      CHECK_PARITY_ERROR = 3'd7
   } state_t;

   localparam logic [1:0] ADDR_INVALID = 2'b11;
   localparam int         NUM_FIFO     = 3;

   // Pick one per-FIFO flag by address; the unused address reads as 0.
   function automatic logic fifo_sel(
      input logic [NUM_FIFO-1:0] flags,
      input logic [1:0]          addr
   );
      logic r;
      r = 1'b0;
      case (addr)
         2'd0:    r = flags[0];
         2'd1:    r = flags[1];
         2'd2:    r = flags[2];
         default: r = 1'b0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/router_fsm_ctrl.sv
// Packet-sequencing FSM for the router input side: header decode,
// write pacing, full stall, parity sequencing and soft-reset abort.
module router_fsm_ctrl
   import router_pkg::*;
#(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             pkt_valid,
   input  logic [1:0]       din,
   input  logic             fifo_full,
   input  logic             empty0,
   input  logic             empty1,
   input  logic             empty2,
   input  logic             sft0,
   input  logic             sft1,
   input  logic             sft2,
   input  logic             parity_done,
   input  logic             low_pkt_valid,
   output logic             det_addr,
   output logic             we_reg,
   output logic             lfd_state,
   output logic             ld_state,
   output logic             laf_state,
   output logic             full_state,
   output logic             rst_int_reg,
   output logic             busy,
   output logic [CNT_W-1:0] pkt_cnt,
   output logic [CNT_W-1:0] drop_cnt
);

   state_t              state;
   state_t              nxt;
   logic [1:0]          addr_q;
   logic [NUM_FIFO-1:0] empty_v;
   logic [NUM_FIFO-1:0] sft_v;
   logic                empty_sel;
   logic                empty_din;
   logic                sft_sel;
   logic                hdr_ok;
   logic                hdr_bad;
   logic                pkt_inc;

   assign empty_v = {empty2, empty1, empty0};
   assign sft_v   = {sft2, sft1, sft0};

   assign empty_sel = fifo_sel(empty_v, addr_q);
   assign sft_sel   = fifo_sel(sft_v, addr_q);
   // Header decode looks at the live address, not the captured one.
   assign empty_din = fifo_sel(empty_v, din);

   assign hdr_bad = (state == DECODE_ADDRESS) && pkt_valid &&
                    (din == ADDR_INVALID);
   assign hdr_ok  = (state == DECODE_ADDRESS) && pkt_valid &&
                    (din != ADDR_INVALID);
   assign pkt_inc = (state == CHECK_PARITY_ERROR) && !fifo_full &&
                    !sft_sel;

   always_comb begin
      nxt = state;
      unique case (state)
         DECODE_ADDRESS: begin
            if (hdr_ok)
               nxt = empty_din ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
         end
         WAIT_TILL_EMPTY: begin
            if (empty_sel)
               nxt = LOAD_FIRST_DATA;
         end
         LOAD_FIRST_DATA: nxt = LOAD_DATA;
         LOAD_DATA: begin
            if (fifo_full)
               nxt = FIFO_FULL_STATE;
            else if (!pkt_valid)
               nxt = LOAD_PARITY;
         end
         FIFO_FULL_STATE: begin
            if (!fifo_full)
               nxt = LOAD_AFTER_FULL;
         end
         LOAD_AFTER_FULL: begin
            if (parity_done)
               nxt = DECODE_ADDRESS;
            else if (low_pkt_valid)
               nxt = LOAD_PARITY;
            else
               nxt = LOAD_DATA;
         end
         LOAD_PARITY: nxt = CHECK_PARITY_ERROR;
         CHECK_PARITY_ERROR: begin
            nxt = fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
         end
         default: nxt = DECODE_ADDRESS;
      endcase
      // Destination soft reset abandons the packet from any load phase.
      if (sft_sel && (state != DECODE_ADDRESS))
         nxt = DECODE_ADDRESS;
   end

   always_ff @(posedge clk) begin
      if (rst)
         state <= DECODE_ADDRESS;
      else
         state <= nxt;
   end

   always_ff @(posedge clk) begin
      if (rst)
         addr_q <= 2'd0;
      else if ((state == DECODE_ADDRESS) && pkt_valid)
         addr_q <= din;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pkt_cnt  <= '0;
         drop_cnt <= '0;
      end else begin
         if (pkt_inc)
            pkt_cnt <= pkt_cnt + CNT_W'(1);
         if (hdr_bad)
            drop_cnt <= drop_cnt + CNT_W'(1);
      end
   end

   always_comb begin
      det_addr    = 1'b0;
      lfd_state   = 1'b0;
      ld_state    = 1'b0;
      full_state  = 1'b0;
      laf_state   = 1'b0;
      rst_int_reg = 1'b0;
      we_reg      = 1'b0;
      busy        = 1'b1;
      unique case (state)
         DECODE_ADDRESS: begin
            det_addr = 1'b1;
            busy     = 1'b0;
         end
         WAIT_TILL_EMPTY: ;
         LOAD_FIRST_DATA: lfd_state = 1'b1;
         LOAD_DATA: begin
            ld_state = 1'b1;
            we_reg   = 1'b1;
            busy     = 1'b0;
         end
         FIFO_FULL_STATE: full_state = 1'b1;
         LOAD_AFTER_FULL: begin
            laf_state = 1'b1;
            we_reg    = 1'b1;
         end
         LOAD_PARITY: we_reg = 1'b1;
         CHECK_PARITY_ERROR: rst_int_reg = 1'b1;
         default: ;
      endcase
   end

endmodule
